// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the MM:SS stopwatch.
// Covers the state encoding, the BCD digit type and the default field maxima.
package stopwatch_pkg;

  localparam int BCD_W       = 4;
  localparam int MIN_MAX_DEF = 59;
  localparam int SEC_MAX_DEF = 59;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ADJUST = 2'd2
  } sw_state_e;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/display bundle between the stopwatch and its environment.
// The optional blink port pair is present only when STOPWATCH_BLINK_EN is defined.
interface stopwatch_counter_if;
  import stopwatch_pkg::*;

  logic clk_1hz;
  logic clk_2hz;
  logic pause_btn;
  logic adj;
  logic sel;
  bcd_t min_tens;
  bcd_t min_ones;
  bcd_t sec_tens;
  bcd_t sec_ones;
  logic paused;
  logic adjusting;
`ifdef STOPWATCH_BLINK_EN
  logic       clk_blink;
  logic [3:0] blank;
`endif

  modport master (
    output clk_1hz, clk_2hz, pause_btn, adj, sel,
`ifdef STOPWATCH_BLINK_EN
    output clk_blink,
    input  blank,
`endif
    input  min_tens, min_ones, sec_tens, sec_ones, paused, adjusting
  );

  modport slave (
    input  clk_1hz, clk_2hz, pause_btn, adj, sel,
`ifdef STOPWATCH_BLINK_EN
    input  clk_blink,
    output blank,
`endif
    output min_tens, min_ones, sec_tens, sec_ones, paused, adjusting
  );

endinterface

// File: rtl/stopwatch_counter_bcd2.sv
// Two-digit BCD counter 00..MAX; inc advances by one, wrapping MAX->00.
// carry is combinational and pulses in the cycle the wrap is taken.
module bcd2_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk_in,
  input  logic rst,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry
);

  localparam bcd_t MAX_TENS = BCD_W'(MAX / 10);
  localparam bcd_t MAX_ONES = BCD_W'(MAX % 10);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    carry  = 1'b0;
    if (inc) begin
      if (tens_q == MAX_TENS && ones_q == MAX_ONES) begin
        tens_d = '0;
        ones_d = '0;
        carry  = 1'b1;
      end else if (ones_q == bcd_t'(9)) begin
        ones_d = '0;
        tens_d = tens_q + bcd_t'(1);
      end else begin
        ones_d = ones_q + bcd_t'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with run/pause/adjust, clocked by edges of sampled 1 Hz / 2 Hz levels.
// Optional blink blanking of the adjusted field under STOPWATCH_BLINK_EN.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX = MIN_MAX_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF
) (
  input logic                clk_in,
  input logic                rst,
  stopwatch_counter_if.slave sw
);

  logic      s1_q, s1_d;
  logic      s2_q, s2_d;
  logic      pause_q, pause_d;
  logic      adjusting_q, adjusting_d;
  sw_state_e state_q, state_d;
  logic      tick_1, tick_2;
  logic      sec_inc, min_inc;
  logic      sec_carry, min_carry_unused;

  always_comb begin
    s1_d        = sw.clk_1hz;
    s2_d        = sw.clk_2hz;
    tick_1      = sw.clk_1hz & ~s1_q;
    tick_2      = sw.clk_2hz & ~s2_q;
    pause_d     = pause_q ^ sw.pause_btn;
    // adj outranks the pause toggle; the flag still flips underneath ADJUST
    state_d     = sw.adj ? ADJUST : (pause_d ? PAUSED : RUN);
    adjusting_d = (state_d == ADJUST);
    sec_inc     = 1'b0;
    min_inc     = 1'b0;
    unique case (state_q)
      RUN: begin
        sec_inc = tick_1;
        min_inc = sec_carry;
      end
      ADJUST: begin
        sec_inc = tick_2 & sw.sel;
        min_inc = tick_2 & ~sw.sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      pause_q     <= 1'b0;
      adjusting_q <= 1'b0;
      state_q     <= RUN;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      pause_q     <= pause_d;
      adjusting_q <= adjusting_d;
      state_q     <= state_d;
    end
  end

  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (sec_inc),
    .tens   (sw.sec_tens),
    .ones   (sw.sec_ones),
    .carry  (sec_carry)
  );

  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (min_inc),
    .tens   (sw.min_tens),
    .ones   (sw.min_ones),
    .carry  (min_carry_unused)
  );

  assign sw.paused    = pause_q;
  assign sw.adjusting = adjusting_q;

`ifdef STOPWATCH_BLINK_EN
  logic [3:0] blank_q, blank_d;

  always_comb begin
    blank_d = 4'b0000;
    if (state_q == ADJUST) begin
      blank_d = sw.sel ? {2'b00, {2{sw.clk_blink}}} : {{2{sw.clk_blink}}, 2'b00};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) blank_q <= 4'b0000;
    else     blank_q <= blank_d;
  end

  assign sw.blank = blank_q;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter; expected digits are hand-computed.
// Inputs change and outputs are sampled 1 time unit after each rising clk_in edge.
module tb_stopwatch_counter;

  logic clk_in;
  logic rst;
  int   total;
  int   passed;
  int   failed;

  stopwatch_counter_if sw ();

  stopwatch_counter #(.MIN_MAX(59), .SEC_MAX(59)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .sw     (sw)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
  endfunction

  task automatic pulse_1hz(input int n);
    for (int i = 0; i < n; i++) begin
      sw.clk_1hz = 1'b1; step(1);
      sw.clk_1hz = 1'b0; step(1);
    end
  endtask

  task automatic pulse_2hz(input int n);
    for (int i = 0; i < n; i++) begin
      sw.clk_2hz = 1'b1; step(1);
      sw.clk_2hz = 1'b0; step(1);
    end
  endtask

  task automatic pulse_both(input int n);
    for (int i = 0; i < n; i++) begin
      sw.clk_1hz = 1'b1; sw.clk_2hz = 1'b1; step(1);
      sw.clk_1hz = 1'b0; sw.clk_2hz = 1'b0; step(1);
    end
  endtask

  task automatic press_pause();
    sw.pause_btn = 1'b1; step(1);
    sw.pause_btn = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    rst = 1'b1;
    sw.clk_1hz = 1'b1; sw.clk_2hz = 1'b0; sw.pause_btn = 1'b0;
    sw.adj = 1'b0; sw.sel = 1'b0;
`ifdef STOPWATCH_BLINK_EN
    sw.clk_blink = 1'b0;
`endif
    step(3);
    check("reset_digits", 32'(digits()), 32'h0000);
    check("reset_paused", 32'(sw.paused), 32'd0);
    check("reset_adjusting", 32'(sw.adjusting), 32'd0);

    // clk_1hz already high at release must not count
    rst = 1'b0; step(5);
    check("no_tick_after_reset", 32'(digits()), 32'h0000);
    sw.clk_1hz = 1'b0; step(1);
    sw.clk_1hz = 1'b1; step(1);
    check("first_tick", 32'(digits()), 32'h0001);
    step(6);
    check("long_high_one_tick", 32'(digits()), 32'h0001);
    sw.clk_1hz = 1'b0; step(1);

    pulse_1hz(4);
    check("run_to_05", 32'(digits()), 32'h0005);
    press_pause();
    check("paused_set", 32'(sw.paused), 32'd1);
    pulse_1hz(3);
    check("paused_hold", 32'(digits()), 32'h0005);
    press_pause();
    check("paused_clear", 32'(sw.paused), 32'd0);
    pulse_1hz(1);
    check("resume_06", 32'(digits()), 32'h0006);
    pulse_2hz(2);
    check("run_ignores_2hz", 32'(digits()), 32'h0006);

    sw.adj = 1'b1; sw.sel = 1'b1; step(1);
    check("adjusting_set", 32'(sw.adjusting), 32'd1);
    pulse_2hz(52);
    check("adj_sec_58", 32'(digits()), 32'h0058);
    pulse_1hz(2);
    check("adj_ignores_1hz", 32'(digits()), 32'h0058);
    sw.adj = 1'b0; step(1);
    check("adj_exit_run", 32'(sw.adjusting), 32'd0);

    pulse_1hz(1);
    check("run_59", 32'(digits()), 32'h0059);
    sw.clk_1hz = 1'b1; step(1);
    check("carry_single_cycle", 32'(digits()), 32'h0100);
    sw.clk_1hz = 1'b0; step(1);
    pulse_1hz(58);
    check("sixty_edges", 32'(digits()), 32'h0158);

    sw.adj = 1'b1; sw.sel = 1'b1; step(1);
    pulse_both(3);
    check("adj_sec_wrap_no_carry", 32'(digits()), 32'h0101);
    sw.sel = 1'b0;
    pulse_2hz(1);
    check("adj_min_after_sel", 32'(digits()), 32'h0201);
    sw.adj = 1'b0; step(1);
    check("adj_exit_adjusting", 32'(sw.adjusting), 32'd0);
    check("adj_exit_not_paused", 32'(sw.paused), 32'd0);

    sw.adj = 1'b1; sw.sel = 1'b0; step(1);
    pulse_2hz(57);
    check("preload_min_59", 32'(digits()), 32'h5901);
    sw.sel = 1'b1;
    pulse_2hz(58);
    check("preload_5959", 32'(digits()), 32'h5959);
    sw.adj = 1'b0; step(1);
    pulse_1hz(1);
    check("full_wrap", 32'(digits()), 32'h0000);

    sw.adj = 1'b1; sw.sel = 1'b0; step(1);
    pulse_2hz(9);
    sw.sel = 1'b1;
    pulse_2hz(9);
    check("preload_0909", 32'(digits()), 32'h0909);
    sw.adj = 1'b0; step(1);
    pulse_1hz(1);
    check("bcd_roll_0910", 32'(digits()), 32'h0910);

    press_pause();
    sw.adj = 1'b1; step(1);
    check("adj_over_pause", 32'(sw.adjusting), 32'd1);
    sw.adj = 1'b0; step(1);
    check("adj_exit_paused_adj", 32'(sw.adjusting), 32'd0);
    check("adj_exit_paused_flag", 32'(sw.paused), 32'd1);
    pulse_1hz(2);
    check("adj_exit_paused_hold", 32'(digits()), 32'h0910);
    press_pause();
    pulse_1hz(1);
    check("resume_0911", 32'(digits()), 32'h0911);

    sw.clk_1hz = 1'b1; sw.pause_btn = 1'b1; rst = 1'b1; step(1);
    rst = 1'b0; sw.pause_btn = 1'b0; sw.clk_1hz = 1'b0;
    check("rst_priority_digits", 32'(digits()), 32'h0000);
    check("rst_priority_paused", 32'(sw.paused), 32'd0);

`ifdef STOPWATCH_BLINK_EN
    check("blank_idle", 32'(sw.blank), 32'h0);
    sw.adj = 1'b1; sw.sel = 1'b0; step(1);
    sw.clk_blink = 1'b1; step(1);
    check("blank_min_on", 32'(sw.blank), 32'hC);
    sw.clk_blink = 1'b0; step(1);
    check("blank_min_off", 32'(sw.blank), 32'h0);
    sw.clk_blink = 1'b1; step(1);
    check("blank_min_on2", 32'(sw.blank), 32'hC);
    sw.sel = 1'b1; step(1);
    check("blank_sec_on", 32'(sw.blank), 32'h3);
    sw.adj = 1'b0; step(3);
    check("blank_exit", 32'(sw.blank), 32'h0);
    sw.clk_blink = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
